// File: rtl/lifo_stack.sv
// Parameterized LIFO stack with programmable pop read latency, high-water flag and
// overflow/underflow error outputs. Define LIFO_STACK_ERR_STICKY_EN to make the error outputs sticky.
module lifo_stack #(
    parameter int depth           = 2,
    parameter int width           = 1,
    parameter int pop_latency     = 0,
    parameter int high_water_mark = 0,
    parameter int CW              = $clog2(depth + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             push,
    input  logic [width-1:0] push_data,
    input  logic             pop,
    output logic [width-1:0] pop_data,
    output logic             pop_valid,
    output logic             full,
    output logic             empty,
    output logic             high_water,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow
);

    localparam int            AW      = (depth > 1) ? $clog2(depth) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(depth);
    localparam logic [CW-1:0] HWM_C   = CW'(high_water_mark);
    localparam bit            HW_EN   = (high_water_mark != 0);

    logic [width-1:0] mem [depth];

    logic [CW-1:0]    count_reg, count_next, count_dec;
    logic             full_reg, full_next;
    logic             empty_reg, empty_next;
    logic             high_water_reg, high_water_next;
    logic             overflow_reg, overflow_next;
    logic             underflow_reg, underflow_next;
    logic             pop_accept, push_accept;
    logic [AW-1:0]    rd_addr, wr_addr;
    logic [width-1:0] top_data;

    // Top of stack lives at count-1; when empty the address is meaningless and the data is never used.
    assign count_dec = count_reg - CW'(1);
    assign rd_addr   = count_dec[AW-1:0];
    assign top_data  = mem[rd_addr];

    always_comb begin
        pop_accept      = enable & pop & ~empty_reg;
        // A push into a full stack is still accepted when a pop frees the top slot in the same cycle.
        push_accept     = enable & push & (~full_reg | pop);
        wr_addr         = pop_accept ? rd_addr : count_reg[AW-1:0];
        count_next      = count_reg;
        if (push_accept && !pop_accept) begin
            count_next = count_reg + CW'(1);
        end else if (pop_accept && !push_accept) begin
            count_next = count_dec;
        end
        full_next       = (count_next == DEPTH_C);
        empty_next      = (count_next == '0);
        high_water_next = HW_EN && (count_next >= HWM_C);
        overflow_next   = enable & push & ~pop & full_reg;
        underflow_next  = enable & pop & empty_reg;
    end

    always_ff @(posedge clock) begin
        if (push_accept) begin
            mem[wr_addr] <= push_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_reg      <= '0;
            full_reg       <= 1'b0;
            empty_reg      <= 1'b1;
            high_water_reg <= 1'b0;
            overflow_reg   <= 1'b0;
            underflow_reg  <= 1'b0;
        end else begin
            count_reg      <= count_next;
            full_reg       <= full_next;
            empty_reg      <= empty_next;
            high_water_reg <= high_water_next;
`ifdef LIFO_STACK_ERR_STICKY_EN
            overflow_reg   <= overflow_reg | overflow_next;
            underflow_reg  <= underflow_reg | underflow_next;
`else
            overflow_reg   <= overflow_next;
            underflow_reg  <= underflow_next;
`endif
        end
    end

    assign count      = count_reg;
    assign full       = full_reg;
    assign empty      = empty_reg;
    assign high_water = high_water_reg;
    assign overflow   = overflow_reg;
    assign underflow  = underflow_reg;

    genvar gi;
    generate
        if (pop_latency == 0) begin : g_lat0
            assign pop_valid = pop_accept;
            assign pop_data  = empty_reg ? '0 : top_data;
        end else begin : g_latn
            // Each stage only loads data alongside a valid, so the output holds its last popped value.
            for (gi = 0; gi < pop_latency; gi++) begin : g_stage
                logic             valid_in;
                logic [width-1:0] data_in;
                logic             valid_reg;
                logic [width-1:0] data_reg;

                if (gi == 0) begin : g_head
                    assign valid_in = pop_accept;
                    assign data_in  = top_data;
                end else begin : g_tail
                    assign valid_in = g_stage[gi-1].valid_reg;
                    assign data_in  = g_stage[gi-1].data_reg;
                end

                always_ff @(posedge clock or posedge reset) begin
                    if (reset) begin
                        valid_reg <= 1'b0;
                        data_reg  <= '0;
                    end else begin
                        valid_reg <= valid_in;
                        if (valid_in) begin
                            data_reg <= data_in;
                        end
                    end
                end
            end
            assign pop_valid = g_stage[pop_latency-1].valid_reg;
            assign pop_data  = g_stage[pop_latency-1].data_reg;
        end
    endgenerate

endmodule

// File: tb/tb_lifo_stack.sv
// Scoreboard bench for lifo_stack: one instance with pop_latency 0 / high-water 3, one with pop_latency 3.
// Expected pops are queued by the stimulus; per-instance monitors check data and arrival cycle.
module tb_lifo_stack;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic       clock = 1'b0;
    int         cyc = 0;
    int         tests = 0;
    int         fails = 0;
    bit         sticky;
    bit         ovf_hit = 1'b0;
    bit         udf_hit = 1'b0;
    exp_t       q0[$];
    exp_t       q3[$];

    logic       rst0 = 1'b0, en0 = 1'b1, push0 = 1'b0, pop0 = 1'b0;
    logic [7:0] data0 = 8'h00;
    logic [7:0] pop_data0;
    logic       pop_valid0, full0, empty0, hw0, ovf0, udf0;
    logic [2:0] count0;

    logic       rst3 = 1'b0, en3 = 1'b1, push3 = 1'b0, pop3 = 1'b0;
    logic [7:0] data3 = 8'h00;
    logic [7:0] pop_data3;
    logic       pop_valid3, full3, empty3, hw3, ovf3, udf3;
    logic [2:0] count3;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    lifo_stack #(.depth(4), .width(8), .pop_latency(0), .high_water_mark(3)) dut0 (
        .clock(clock), .reset(rst0), .enable(en0), .push(push0), .push_data(data0), .pop(pop0),
        .pop_data(pop_data0), .pop_valid(pop_valid0), .full(full0), .empty(empty0),
        .high_water(hw0), .count(count0), .overflow(ovf0), .underflow(udf0)
    );

    lifo_stack #(.depth(4), .width(8), .pop_latency(3), .high_water_mark(0)) dut3 (
        .clock(clock), .reset(rst3), .enable(en3), .push(push3), .push_data(data3), .pop(pop3),
        .pop_data(pop_data3), .pop_valid(pop_valid3), .full(full3), .empty(empty3),
        .high_water(hw3), .count(count3), .overflow(ovf3), .underflow(udf3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("[TB] ok   %s = %0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic op0(input logic e, input logic pu, input logic [7:0] d, input logic po);
        en0 = e; push0 = pu; data0 = d; pop0 = po;
        tick();
        en0 = 1'b1; push0 = 1'b0; pop0 = 1'b0;
    endtask

    task automatic op3(input logic pu, input logic [7:0] d, input logic po);
        push3 = pu; data3 = d; pop3 = po;
        tick();
        push3 = 1'b0; pop3 = 1'b0;
    endtask

    task automatic expect0(input logic [7:0] d);
        exp_t e;
        e.data = d;
        e.cyc  = cyc;
        q0.push_back(e);
    endtask

    task automatic expect3(input logic [7:0] d);
        exp_t e;
        e.data = d;
        e.cyc  = cyc + 3;
        q3.push_back(e);
    endtask

    // Monitors: every pop_valid must match the oldest queued expectation, in data and in cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (pop_valid0 === 1'b1) begin
                if (q0.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL lat0_unexpected_valid: got pop_data %0h expected no pop_valid", pop_data0);
                end else begin
                    e = q0.pop_front();
                    chk("lat0_pop_data", 32'(pop_data0), 32'(e.data));
                    chk("lat0_pop_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (pop_valid3 === 1'b1) begin
                if (q3.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL lat3_unexpected_valid: got pop_data %0h expected no pop_valid", pop_data3);
                end else begin
                    e = q3.pop_front();
                    chk("lat3_pop_data", 32'(pop_data3), 32'(e.data));
                    chk("lat3_pop_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
`ifdef LIFO_STACK_ERR_STICKY_EN
        sticky = 1'b1;
`else
        sticky = 1'b0;
`endif
        #1;
        rst0 = 1'b1; rst3 = 1'b1;
        tick(); tick();
        rst0 = 1'b0;
        chk("rst_count", 32'(count0), 0);
        chk("rst_empty", 32'(empty0), 1);
        chk("rst_full", 32'(full0), 0);
        chk("rst_high_water", 32'(hw0), 0);
        chk("rst_pop_valid", 32'(pop_valid0), 0);
        chk("rst_pop_data", 32'(pop_data0), 0);
        chk("rst_overflow", 32'(ovf0), 0);
        chk("rst_underflow", 32'(udf0), 0);

        // Fill, watching high_water rise on the third push.
        op0(1, 1, 8'h11, 0);
        op0(1, 1, 8'h22, 0);
        chk("count_2", 32'(count0), 2);
        chk("hw_below_mark", 32'(hw0), 0);
        op0(1, 1, 8'h33, 0);
        chk("hw_at_mark", 32'(hw0), 1);
        op0(1, 1, 8'h44, 0);
        chk("full_count", 32'(count0), 4);
        chk("full_flag", 32'(full0), 1);

        op0(1, 1, 8'h55, 0);
        ovf_hit = 1'b1;
        chk("overflow_pulse", 32'(ovf0), 1);
        chk("overflow_count", 32'(count0), 4);
        op0(1, 0, 8'h00, 0);
        chk("overflow_after", 32'(ovf0), 32'(sticky & ovf_hit));

        // Push+pop on a full stack swaps the top entry.
        expect0(8'h44);
        op0(1, 1, 8'h99, 1);
        chk("swap_count", 32'(count0), 4);
        chk("swap_no_overflow", 32'(ovf0), 32'(sticky & ovf_hit));

        expect0(8'h99); op0(1, 0, 8'h00, 1);
        chk("hw_hold_3", 32'(hw0), 1);
        expect0(8'h33); op0(1, 0, 8'h00, 1);
        chk("hw_clear_2", 32'(hw0), 0);
        expect0(8'h22); op0(1, 0, 8'h00, 1);
        expect0(8'h11); op0(1, 0, 8'h00, 1);
        chk("drained_empty", 32'(empty0), 1);
        chk("drained_count", 32'(count0), 0);

        // Pop on empty: underflow only.
        pop0 = 1'b1;
        #3;
        chk("uf_no_valid", 32'(pop_valid0), 0);
        tick();
        pop0 = 1'b0;
        udf_hit = 1'b1;
        chk("underflow_pulse", 32'(udf0), 1);
        chk("underflow_count", 32'(count0), 0);
        op0(1, 0, 8'h00, 0);
        chk("underflow_after", 32'(udf0), 32'(sticky & udf_hit));

        // Push+pop on empty: push accepted, underflow flagged.
        op0(1, 1, 8'hAA, 1);
        chk("pp_empty_count", 32'(count0), 1);
        chk("pp_empty_underflow", 32'(udf0), 1);
        expect0(8'hAA); op0(1, 0, 8'h00, 1);
        chk("pp_empty_drained", 32'(count0), 0);

        // enable low freezes everything.
        op0(1, 1, 8'h5A, 0);
        for (int i = 0; i < 5; i++) begin
            op0(0, 1, 8'hC3, 1);
            chk("dis_count", 32'(count0), 1);
            chk("dis_overflow", 32'(ovf0), 32'(sticky & ovf_hit));
            chk("dis_underflow", 32'(udf0), 32'(sticky & udf_hit));
        end
        expect0(8'h5A); op0(1, 0, 8'h00, 1);
        chk("dis_final_empty", 32'(empty0), 1);

        // Latency-3 instance.
        rst3 = 1'b0;
        op3(1, 8'h01, 0);
        op3(1, 8'h02, 0);
        chk("lat3_count", 32'(count3), 2);
        chk("lat3_hw_disabled", 32'(hw3), 0);
        expect3(8'h02); op3(0, 8'h00, 1);
        expect3(8'h01); op3(0, 8'h00, 1);
        for (int i = 0; i < 5; i++) tick();
        chk("lat3_valid_low", 32'(pop_valid3), 0);
        chk("lat3_data_hold", 32'(pop_data3), 8'h01);

        // Reset while a pop is in flight: no pop_valid afterwards.
        op3(1, 8'h03, 0);
        op3(0, 8'h00, 1);
        rst3 = 1'b1;
        tick();
        rst3 = 1'b0;
        chk("abort_count", 32'(count3), 0);
        chk("abort_pop_data", 32'(pop_data3), 0);
        for (int i = 0; i < 6; i++) tick();
        chk("abort_valid_low", 32'(pop_valid3), 0);

        chk("q0_drained", q0.size(), 0);
        chk("q3_drained", q3.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lifo_stack.md
Name: lifo_stack

Overview:
- Synthesizable parameterized LIFO stack: the storage element that a stack checker monitors, driving the full/empty/pop_data side of the push/pop interface.
- Used as a reusable buffer in the library and as the reference DUT for stack checker regression benches.
- Provides a programmable pop read latency, a high-water indication and overflow/underflow error strobes.

Parameters:
- depth, 2, number of entries; must be >= 2.
- width, 1, data width in bits; must be >= 1.
- pop_latency, 0, cycles from an accepted pop to pop_data/pop_valid; legal values 0..4.
- high_water_mark, 0, occupancy at or above which high_water asserts; 0 disables high_water, which is then held low.
- CW, $clog2(depth+1), width of count. Derived; do not override.

Ports:
- clock  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  when low, push and pop are ignored and all state holds; the pop_latency pipeline still advances.
- push  input  1  push request.
- push_data  input  width  data written on an accepted push.
- pop  input  1  pop request.
- pop_data  output  width  popped data.
- pop_valid  output  1  pop_data qualifier.
- full  output  1  count == depth.
- empty  output  1  count == 0.
- high_water  output  1  high_water_mark != 0 and count >= high_water_mark.
- count  output  CW  current occupancy.
- overflow  output  1  push rejected because the stack is full and no pop occurred in the same cycle.
- underflow  output  1  pop rejected because the stack is empty.

Behaviour:
- Reset, asynchronous and active-high:
  - count = 0, empty = 1, full = 0, high_water = 0.
  - pop_valid = 0, pop_data = 0, overflow = 0, underflow = 0.
  - pop_latency pipeline cleared. Storage array contents are not reset.
  - Reset asserted mid-operation aborts any in-flight pop; no pop_valid is produced after reset.
- Flags full, empty, high_water and count are registered and reflect state after the last clock edge.
- Accept rules, evaluated only when enable = 1:
  - push alone, not full: mem[count] <= push_data; count += 1.
  - push alone, full: overflow pulses for 1 cycle; no state change.
  - pop alone, not empty: top entry mem[count-1] is read; count -= 1.
  - pop alone, empty: underflow pulses for 1 cycle; no read; pop_valid stays 0.
  - push and pop, not empty (including full): the pop returns the old top, push_data overwrites mem[count-1], and count is unchanged. No overflow.
  - push and pop, empty: the push is accepted (count becomes 1) and underflow pulses.
- enable = 0: push and pop are ignored and no error pulses are generated.
- pop_latency = 0: pop_data is combinational mem[count-1], gated to 0 when empty; pop_valid = pop & enable & !empty in the same cycle.
- pop_latency = L > 0:
  - Read data and valid are captured at the accepting edge, then shifted through L-1 further register stages.
  - pop_valid is asserted exactly L cycles after the pop cycle, for 1 cycle per accepted pop.
  - Back-to-back pops produce back-to-back pop_valid.
  - pop_data holds its last value while pop_valid = 0.
- Wrap-around: none; this is a linear stack, and count saturates at 0 and depth through the reject rules.
- Count arithmetic is in CW bits; depth must fit in CW bits, which the derived width guarantees.

Optional Feature:
- Macro: LIFO_STACK_ERR_STICKY_EN.
- Defined: overflow and underflow are sticky; once set they stay high until reset.
- Undefined (default): overflow and underflow are single-cycle pulses coincident with the cycle after the offending request edge.

Test Plan:
- depth=4, width=8, pop_latency=0: push 0x11, 0x22, 0x33, 0x44 -> full=1, count=4; a 5th push of 0x55 -> overflow pulses, count stays 4; 4 pops return 0x44, 0x33, 0x22, 0x11 with pop_valid in the same cycle, then empty=1.
- Pop when empty -> underflow=1 for 1 cycle, pop_valid=0, count=0; simultaneous push 0xAA + pop when empty -> count=1, underflow=1, next pop returns 0xAA.
- Full stack (top 0x44): push 0x99 + pop in one cycle -> returns 0x44, count stays 4, no overflow; next pop returns 0x99.
- pop_latency=3: push 0x01, 0x02; pop on two consecutive cycles -> pop_valid high 3 and 4 cycles later with 0x02 then 0x01; assert reset between the pop and its pop_valid -> no pop_valid is produced.
- high_water_mark=3, depth=4: pushes raise count 2->3 -> high_water rises on the 3rd push edge; a pop falls it back 3->2 -> high_water clears.
- enable=0 with push=1 and pop=1 held for 5 cycles -> count, flags and errors unchanged; with LIFO_STACK_ERR_STICKY_EN defined, overflow stays high after a rejected push until reset.
